// File: rtl/odo_pkg.sv
// Shared definitions for the Odocrypt nonce collector.
// Provides the nonce width, default holdoff, FSM state encoding and
// the width of one result entry {core_id, nonce}.
package odo_pkg;

  localparam int unsigned NONCE_W             = 32;
  localparam logic [7:0]  ODO_HOLDOFF_DEFAULT = 8'hCD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_RUN     = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  // Width of one stored result: {core_id, nonce}
  function automatic int unsigned entry_w(input int unsigned core_id_w);
    return NONCE_W + core_id_w;
  endfunction

endpackage

// File: rtl/odo_nonce_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clr           drops all entries (priority over push/pop)
//   wr_en/wr_data push; accepted when not full or when popping this cycle
//   rd_en         pop head; ignored when empty
//   rd_data       head entry (valid while !empty)
//   empty, full   registered status flags
//   level         entries held
module odo_nonce_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic             push_c, pop_c;

  assign pop_c  = rd_en && !empty;
  assign push_c = wr_en && (!full || pop_c) && !clr;

  // Pointer update; extra MSB distinguishes full from empty
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      empty    <= (wr_ptr_d == rd_ptr_d);
      full     <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end
  end

  // Storage needs no reset; contents are only visible while !empty
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q[AW-1:0]];
  assign level   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/odo_nonce_collector.sv
// Collects golden-nonce hits from NUM_CORES miner cores, suppresses them
// during the post-start holdoff, arbitrates round-robin into a result FIFO
// and presents results to the host interface with an ack handshake.
// Ports:
//   clk_h, rst_h   hashing clock, synchronous active-high reset
//   start_hash     level, mining active
//   host_break     pulse, flush results and restart holdoff
//   core_ticket    per-core hit pulse; core_nonce holds the matching nonces
//   ticket2moon    result valid on nonce/core_id
//   nonce_ack      consumer pops the presented result
//   fifo_level     entries held; overflow sticky hit-drop flag
module odo_nonce_collector
  import odo_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned HOLDOFF    = 32'(ODO_HOLDOFF_DEFAULT),
  parameter int unsigned CORE_ID_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           clk_h,
  input  logic                           rst_h,
  input  logic                           start_hash,
  input  logic                           host_break,
  input  logic [NUM_CORES-1:0]           core_ticket,
  input  logic [NUM_CORES*NONCE_W-1:0]   core_nonce,
  output logic                           ticket2moon,
  output logic [NONCE_W-1:0]             nonce,
  output logic [CORE_ID_W-1:0]           core_id,
  input  logic                           nonce_ack,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic                           overflow
);

  localparam int unsigned EW   = entry_w(CORE_ID_W);
  localparam int unsigned HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  state_t               state_q, state_d;
  logic [HC_W-1:0]      cnt_q, cnt_d;
  logic [NUM_CORES-1:0] pend_v_q, pend_v_d;
  logic [NONCE_W-1:0]   pend_n_q [NUM_CORES];
  logic [NONCE_W-1:0]   pend_n_d [NUM_CORES];
  logic [CORE_ID_W-1:0] rr_q, rr_d, gidx_c;
  logic                 ovf_q, ovf_d;
  logic [EW-1:0]        last_q, head_c;
  logic [NUM_CORES-1:0] grant_oh_c;
  logic                 grant_c, can_write_c, clr_c;
  logic                 fifo_empty, fifo_full;

  // Next state and the clear condition for FIFO, pending slots and overflow
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    clr_c   = host_break || (state_q == ST_FLUSH) ||
              (!start_hash && (state_q != ST_FLUSH));
    if (host_break) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE:    if (start_hash) state_d = (HOLDOFF == 0) ? ST_RUN : ST_HOLDOFF;
        ST_HOLDOFF: begin
          if (!start_hash)                       state_d = ST_IDLE;
          else if (cnt_q == HC_W'(HOLDOFF - 1))  state_d = ST_RUN;
          else                                   cnt_d   = cnt_q + HC_W'(1);
        end
        ST_RUN:     if (!start_hash) state_d = ST_IDLE;
        ST_FLUSH:   state_d = start_hash ? ((HOLDOFF == 0) ? ST_RUN : ST_HOLDOFF)
                                         : ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Round-robin arbiter: first valid slot at or after rr_q
  always_comb begin
    grant_oh_c  = '0;
    grant_c     = 1'b0;
    gidx_c      = '0;
    rr_d        = rr_q;
    can_write_c = (state_q == ST_RUN) && !clr_c &&
                  (!fifo_full || (nonce_ack && !fifo_empty));
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      int unsigned idx;
      idx = (32'(rr_q) + k) % NUM_CORES;
      if (can_write_c && !grant_c && pend_v_q[idx]) begin
        grant_c         = 1'b1;
        grant_oh_c[idx] = 1'b1;
        gidx_c          = CORE_ID_W'(idx);
        rr_d            = CORE_ID_W'((idx + 1) % NUM_CORES);
      end
    end
  end

  // Pending slot capture; a ticket on a held, ungranted slot is dropped
  always_comb begin
    pend_v_d = pend_v_q;
    pend_n_d = pend_n_q;
    ovf_d    = ovf_q;
    if (clr_c) begin
      pend_v_d = '0;
      ovf_d    = 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        if (grant_oh_c[i]) pend_v_d[i] = 1'b0;
        if ((state_q == ST_RUN) && core_ticket[i]) begin
          if (pend_v_q[i] && !grant_oh_c[i]) begin
            ovf_d = 1'b1;
          end else begin
            pend_v_d[i] = 1'b1;
            pend_n_d[i] = core_nonce[i*NONCE_W +: NONCE_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pend_v_q <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) pend_n_q[i] <= '0;
      rr_q     <= '0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_v_q <= pend_v_d;
      pend_n_q <= pend_n_d;
      rr_q     <= rr_d;
      ovf_q    <= ovf_d;
      if (!fifo_empty) last_q <= head_c;
    end
  end

  odo_nonce_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_h),
    .rst     (rst_h),
    .clr     (clr_c),
    .wr_en   (grant_c),
    .wr_data ({gidx_c, pend_n_q[gidx_c]}),
    .rd_en   (nonce_ack),
    .rd_data (head_c),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  // Outputs hold the last presented entry once the FIFO drains
  assign ticket2moon = !fifo_empty;
  assign nonce       = fifo_empty ? last_q[NONCE_W-1:0]  : head_c[NONCE_W-1:0];
  assign core_id     = fifo_empty ? last_q[EW-1:NONCE_W] : head_c[EW-1:NONCE_W];
  assign overflow    = ovf_q;

endmodule
